face_fetch_ctrl: RTL

FACE_FETCH_CTRL -- requirements
Module: face_fetch_ctrl

---
 rtl/face_fetch_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/face_fetch_ctrl.sv
// Streams one frame of faces from object memory to the GPU pipeline through a
// 2-entry credit-managed output FIFO, with in-order addressing and abort support.
module face_fetch_ctrl #(
  parameter int unsigned FACES  = 92,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned FACE_W = 288
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [FACE_W-1:0] mem_data,
  output logic [FACE_W-1:0] face,
  output logic [ADDR_W-1:0] face_idx,
  output logic              face_valid,
  input  logic              face_ready,
  output logic              face_last
);

  localparam logic [ADDR_W:0] LastCnt = (ADDR_W+1)'(FACES - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     issue_cnt_q, issue_cnt_d;
  logic [ADDR_W:0]     out_cnt_q, out_cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                inflight_q, inflight_d;
  logic [ADDR_W-1:0]   infl_idx_q, infl_idx_d;
  logic                done_q, done_d;
  logic [1:0]          count_q, count_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic                fifo_we;
  logic [FACE_W-1:0]   fifo_data_q [2];
  logic [ADDR_W-1:0]   fifo_idx_q  [2];

  logic pop;
  logic push;
  logic credit;
  logic issue;

  assign face_valid = (count_q != 2'd0);
  assign pop        = face_valid && face_ready;
  assign push       = inflight_q;
  // Occupancy the FIFO will reach once the read in flight lands, net of this cycle's pop.
  assign credit     = ({1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2;
  assign issue      = (state_q == StFetch) && credit;

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    mem_addr_d  = mem_addr_q;
    inflight_d  = issue;
    infl_idx_d  = mem_addr_q;
    done_d      = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_we     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StFetch;
          issue_cnt_d = '0;
          out_cnt_d   = '0;
          mem_addr_d  = '0;
        end
      end
      StFetch: begin
        if (issue) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_q == LastCnt) begin
            state_d = StDrain;
          end else begin
            mem_addr_d = mem_addr_q + 1'b1;
          end
        end
      end
      StDrain: begin
      end
      default: state_d = StIdle;
    endcase

    if (push) begin
      fifo_we  = 1'b1;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d  = ~rd_ptr_q;
      out_cnt_d = out_cnt_q + 1'b1;
      if (face_last) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};

    // Abort cancels everything, including a start in the same cycle.
    if (abort) begin
      state_d     = StIdle;
      issue_cnt_d = '0;
      out_cnt_d   = '0;
      mem_addr_d  = mem_addr_q;
      inflight_d  = 1'b0;
      done_d      = 1'b0;
      count_d     = 2'd0;
      wr_ptr_d    = 1'b0;
      rd_ptr_d    = 1'b0;
      fifo_we     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      mem_addr_q  <= '0;
      inflight_q  <= 1'b0;
      infl_idx_q  <= '0;
      done_q      <= 1'b0;
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      mem_addr_q  <= mem_addr_d;
      inflight_q  <= inflight_d;
      infl_idx_q  <= infl_idx_d;
      done_q      <= done_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Payload storage needs no reset: outputs are gated by face_valid.
  always_ff @(posedge clk) begin
    if (fifo_we) begin
      fifo_data_q[wr_ptr_q] <= mem_data;
      fifo_idx_q[wr_ptr_q]  <= infl_idx_q;
    end
  end

  assign busy       = (state_q != StIdle);
  assign frame_done = done_q;
  assign mem_addr   = mem_addr_q;
  assign face       = face_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign face_idx   = face_valid ? fifo_idx_q[rd_ptr_q] : '0;
  assign face_last  = face_valid && (out_cnt_q == LastCnt);

endmodule
